cv_line_fetch: RTL and testbench

//  Downstream consumer of cv_timing. During each line it prefetches the next visible line
//  (selected by sp_v_count/sp_v_active) from frame memory over a req/ack bus into a

---
 rtl/cv_line_fetch_if.sv | 20 ++
 rtl/cv_line_fetch.sv | 144 ++++++++++++++
 tb/tb_cv_line_fetch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv_line_fetch_if.sv
// Frame-memory read bus: req/ack with same-clock read data.
// master = line fetcher (drives req/addr), slave = memory.
interface cv_line_fetch_if #(
  parameter int ADDR_W = 20
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cv_line_fetch.sv
// Line prefetcher: fills one bank of a ping-pong buffer over mem while
// streaming 8-bit pixels from the other bank (clk, reset_n, cs, timing in, pix out).
module cv_line_fetch #(
  parameter int H_PIXELS    = 800,
  parameter int LINE_WORDS  = 200,
  parameter int ADDR_W      = 20,
  parameter int BASE_ADDR   = 0,
  parameter int LINE_STRIDE = 200
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cs,
  input  logic                   h_en,
  input  logic                   h_active,
  input  logic [10:0]            h_count,
  input  logic                   h_end,
  input  logic                   sp_v_active,
  input  logic [9:0]             sp_v_count,
  cv_line_fetch_if.master        mem,
  output logic                   pix_valid,
  output logic [7:0]             pix_data,
  output logic                   underrun
);
  localparam int WW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(2 * LINE_WORDS);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, state_nxt;
  logic              h_end_d;
  logic              line_ev;
  logic              rd_bank;
  logic [1:0]        bank_ok;
  logic              fetch_done;
  logic [WW-1:0]     word;
  logic [ADDR_W-1:0] line_base;
  logic              last_word;
  logic              wr_en;
  logic              rd_en;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic [31:0]       lbuf [2*LINE_WORDS];
  logic [31:0]       rd_word;
  logic [1:0]        rd_lane;
  logic              rd_ok;
  logic              rd_v;

  assign line_ev   = h_end & ~h_end_d;
  assign last_word = (word == WW'(LINE_WORDS - 1));
  assign wr_en     = (state == FETCH) & mem.mem_ack;
  assign line_base = ADDR_W'(BASE_ADDR)
                   + ADDR_W'(32'(sp_v_count) * LINE_STRIDE);

  always_comb begin
    state_nxt   = state;
    mem.mem_req = 1'b0;
    if (state == FETCH) mem.mem_req = 1'b1;
    if (line_ev)
      state_nxt = sp_v_active ? FETCH : IDLE;
    else if (wr_en && last_word)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  state <= IDLE;
    else if (!cs)  state <= IDLE;
    else           state <= state_nxt;
  end

  // mem_addr runs alongside word; the ADDR_W-bit add gives the wrap.
  // A line event overrides any same-clock ack bookkeeping (abort).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_end_d      <= 1'b0;
      rd_bank      <= 1'b0;
      bank_ok      <= 2'b00;
      fetch_done   <= 1'b0;
      word         <= '0;
      mem.mem_addr <= '0;
      underrun     <= 1'b0;
    end else if (!cs) begin
      h_end_d      <= 1'b0;
      rd_bank      <= 1'b0;
      bank_ok      <= 2'b00;
      fetch_done   <= 1'b0;
      word         <= '0;
      mem.mem_addr <= '0;
      underrun     <= 1'b0;
    end else begin
      h_end_d <= h_end;
      if (wr_en) begin
        if (last_word) begin
          fetch_done <= 1'b1;
        end else begin
          word         <= word + 1'b1;
          mem.mem_addr <= mem.mem_addr + 1'b1;
        end
      end
      if (line_ev) begin
        rd_bank           <= ~rd_bank;
        bank_ok[~rd_bank] <= fetch_done;
        bank_ok[rd_bank]  <= 1'b0;
        fetch_done        <= 1'b0;
        word              <= '0;
        if (state == FETCH) underrun <= 1'b1;
        if (sp_v_active) mem.mem_addr <= line_base;
      end
    end
  end

  assign wr_idx = IW'(rd_bank ? 0 : LINE_WORDS) + IW'(word);
  assign rd_idx = IW'(rd_bank ? LINE_WORDS : 0) + IW'(h_count[10:2]);
  assign rd_en  = h_active & h_en & (h_count < 11'(H_PIXELS));

  always_ff @(posedge clk) begin
    if (wr_en) lbuf[wr_idx] <= mem.mem_rdata;
    if (rd_en) rd_word <= lbuf[rd_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v      <= 1'b0;
      rd_lane   <= 2'b00;
      rd_ok     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= 8'h00;
    end else if (!cs) begin
      rd_v      <= 1'b0;
      rd_lane   <= 2'b00;
      rd_ok     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= 8'h00;
    end else begin
      rd_v      <= rd_en;
      pix_valid <= rd_v;
      if (rd_en) begin
        rd_lane <= h_count[1:0];
        rd_ok   <= bank_ok[rd_bank];
      end
      if (rd_v)
        pix_data <= rd_ok ? rd_word[{rd_lane, 3'b000} +: 8] : 8'h00;
    end
  end
endmodule

// File: tb/tb_cv_line_fetch.sv
// Scoreboard bench for cv_line_fetch: small line geometry, memory
// model with selectable ack behaviour, wrapping base address.
module tb_cv_line_fetch;
  localparam int HP     = 16;
  localparam int LW     = 4;
  localparam int AW     = 20;
  localparam int BASE   = 'hFFFF2;
  localparam int STRIDE = 4;
  localparam int HT     = 24;

  typedef struct {
    bit vis;
    int y;
    bit ok;
  } ln_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        h_en = 1'b0;
  logic        h_active = 1'b0;
  logic [10:0] h_count = '0;
  logic        h_end = 1'b0;
  logic        sp_v_active = 1'b0;
  logic [9:0]  sp_v_count = '0;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        underrun;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_mode = 0;
  int unsigned cyc = 0;
  logic [7:0]  sbq[$];
  logic [7:0]  exp_q;
  ln_t         cur = '{0, 0, 0};
  ln_t         pipe = '{0, 0, 0};
  bit          killed;

  cv_line_fetch_if #(.ADDR_W(AW)) bus ();

  cv_line_fetch #(
    .H_PIXELS(HP), .LINE_WORDS(LW), .ADDR_W(AW),
    .BASE_ADDR(BASE), .LINE_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs),
    .h_en(h_en), .h_active(h_active), .h_count(h_count),
    .h_end(h_end), .sp_v_active(sp_v_active),
    .sp_v_count(sp_v_count), .mem(bus),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(a * 13 + k * 71 + 5);
    return w;
  endfunction

  function automatic logic [7:0] exp_pix(input int y, input int x);
    logic [AW-1:0] a;
    logic [31:0] w;
    a = AW'(BASE + y * STRIDE + x / 4);
    w = mem_word(a);
    return w[8*(x%4) +: 8];
  endfunction

  // 0: ack every clock (even with no request), 1: every 8th clock, 2: never
  always_comb begin
    bus.mem_ack = 1'b0;
    case (ack_mode)
      0:       bus.mem_ack = 1'b1;
      1:       bus.mem_ack = bus.mem_req && (cyc % 8 == 0);
      default: bus.mem_ack = 1'b0;
    endcase
    bus.mem_rdata = mem_word(bus.mem_addr);
  end

  logic          h_end_q = 1'b0;
  logic          chk_q = 1'b0;
  logic [AW-1:0] addr_q = '0;
  always @(posedge clk) h_end_q <= h_end;

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL pix_extra: got %02h, none expected", pix_data);
      end else begin
        exp_q = sbq.pop_front();
        if (pix_data !== exp_q) begin
          n_bad++;
          $display("FAIL pix_data: got %02h want %02h", pix_data, exp_q);
        end
      end
    end
    if (chk_q && reset_n && cs) begin
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr_q) begin
        n_bad++;
        $display("FAIL req_hold: req %0b addr %05h want req 1 addr %05h",
                 bus.mem_req, bus.mem_addr, addr_q);
      end
    end
    chk_q  = bus.mem_req && !bus.mem_ack && !(h_end && !h_end_q)
           && reset_n && cs;
    addr_q = bus.mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kill(input bit use_rst);
    if (use_rst) begin
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.mem_req, bus.mem_addr, pix_valid, pix_data, underrun} !== '0)
      begin
        n_bad++;
        $display("FAIL async_reset: req %0b addr %05h pv %0b pd %02h ur %0b want 0",
                 bus.mem_req, bus.mem_addr, pix_valid, pix_data, underrun);
      end
      tick();
      reset_n = 1'b1;
    end else begin
      cs = 1'b0;
      tick();
      n_cmp++;
      if ({bus.mem_req, underrun, pix_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL cs_clear: req %0b ur %0b pv %0b want 0 0 0",
                 bus.mem_req, underrun, pix_valid);
      end
      cs = 1'b1;
    end
    killed = 1'b1;
  endtask

  // One line: pixels at h_count 0..HP-1, h_end rises at HP-1.
  // The request made at a line's event is displayed two lines later.
  task automatic do_line(input bit nvis, input int ny,
                         input int hstep = 1, input int kill_at = -1,
                         input bit use_rst = 1'b0);
    logic [AW-1:0] ea;
    killed = 1'b0;
    ea = AW'(BASE + ny * STRIDE);
    for (int hc = 0; hc < HT; hc++) begin
      h_count     = 11'(hc);
      h_active    = cur.vis && (hc < HP);
      h_end       = (hc == HP - 1) || (hc == HP);
      sp_v_active = nvis;
      sp_v_count  = 10'(ny);
      h_en        = 1'b1;
      if (h_active) sbq.push_back(cur.ok ? exp_pix(cur.y, hc) : 8'h00);
      tick();
      h_en = 1'b0;
      if (hc == HP - 1) begin
        n_cmp++;
        if (bus.mem_req !== nvis || (nvis && bus.mem_addr !== ea)) begin
          n_bad++;
          $display("FAIL line_start y=%0d: req %0b addr %05h want req %0b addr %05h",
                   ny, bus.mem_req, bus.mem_addr, nvis, ea);
        end
      end
      for (int s = 1; s < hstep; s++) tick();
      if (hc == kill_at) kill(use_rst);
    end
    cur  = pipe;
    pipe = '{vis: nvis, y: ny, ok: nvis && ack_mode == 0};
    if (killed) begin
      cur.ok  = 1'b0;
      pipe.ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({bus.mem_req, bus.mem_addr, pix_valid, pix_data, underrun} !== '0)
    begin
      n_bad++;
      $display("FAIL reset_state: req %0b addr %05h pv %0b pd %02h ur %0b want 0",
               bus.mem_req, bus.mem_addr, pix_valid, pix_data, underrun);
    end
    reset_n = 1'b1;
    cs = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_ideal_frame();
    int ys[6] = '{0, 1, 2, 3, 4, 10};
    ack_mode = 0;
    foreach (ys[i]) do_line(1'b1, ys[i]);
    repeat (3) do_line(1'b0, 0);
    n_cmp++;
    if (underrun !== 1'b0 || sbq.size() != 0) begin
      n_bad++;
      $display("FAIL ideal_end: ur %0b left %0d want 0 0", underrun, sbq.size());
    end
  endtask

  task automatic test_half_rate();
    ack_mode = 0;
    do_line(1'b1, 5, 2);
    do_line(1'b1, 6, 2);
    repeat (3) do_line(1'b0, 0, 2);
    n_cmp++;
    if (underrun !== 1'b0 || sbq.size() != 0) begin
      n_bad++;
      $display("FAIL half_end: ur %0b left %0d want 0 0", underrun, sbq.size());
    end
  endtask

  task automatic test_slow_ack();
    ack_mode = 1;
    for (int y = 20; y < 23; y++) do_line(1'b1, y);
    repeat (3) do_line(1'b0, 0);
    n_cmp++;
    if (underrun !== 1'b1 || sbq.size() != 0) begin
      n_bad++;
      $display("FAIL slow_end: ur %0b left %0d want 1 0", underrun, sbq.size());
    end
  endtask

  task automatic test_cs_clear();
    ack_mode = 1;
    do_line(1'b1, 30, 1, HP + 3, 1'b0);
    ack_mode = 0;
    for (int y = 31; y < 34; y++) do_line(1'b1, y);
    repeat (3) do_line(1'b0, 0);
    n_cmp++;
    if (underrun !== 1'b0 || sbq.size() != 0) begin
      n_bad++;
      $display("FAIL cs_end: ur %0b left %0d want 0 0", underrun, sbq.size());
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] ea;
    ack_mode = 2;
    ea = AW'(BASE + 7 * STRIDE);
    do_line(1'b1, 7);
    repeat (100) tick();
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== ea) begin
      n_bad++;
      $display("FAIL stall_hold: req %0b addr %05h want 1 %05h",
               bus.mem_req, bus.mem_addr, ea);
    end
  endtask

  task automatic test_async_reset();
    do_line(1'b1, 9, 1, HP + 4, 1'b1);
    ack_mode = 0;
    do_line(1'b1, 11);
    do_line(1'b1, 12);
    repeat (3) do_line(1'b0, 0);
    n_cmp++;
    if (underrun !== 1'b0 || sbq.size() != 0) begin
      n_bad++;
      $display("FAIL reset_end: ur %0b left %0d want 0 0", underrun, sbq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ideal_frame();
    test_half_rate();
    test_slow_ack();
    test_cs_clear();
    test_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
